// File: rtl/alu_if.sv
// Operand/opcode/result bundle for the execute-stage ALU.
// The master side drives the operands; the slave (the ALU) drives the result and flags.
interface alu_if;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] opcode;
   logic [7:0] ALU_OUT;
   logic       Zero_Flag;
   logic       Negative_Flag;
   logic       Carry_Flag;
   logic       Overflow;

   modport master (
      output A, B, opcode,
      input  ALU_OUT, Zero_Flag, Negative_Flag, Carry_Flag, Overflow
   );

   modport slave (
      input  A, B, opcode,
      output ALU_OUT, Zero_Flag, Negative_Flag, Carry_Flag, Overflow
   );
endinterface

// File: rtl/alu.sv
// Registered 8-bit ALU with persistent Z/N/C/V flags; C also feeds the rotate-through-carry ops.
// Build option: define ALU_MOV_EN to enable opcode 0001 as MOV; otherwise 0001 behaves as NOP.
module alu (
   input  logic  CLK,
   input  logic  RST,
   alu_if.slave  bus
);

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_MOV   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_ROT   = 4'b0110;
   localparam logic [3:0] OP_UNARY = 4'b1000;

   localparam logic [1:0] SUB_RLC  = 2'b00;
   localparam logic [1:0] SUB_RRC  = 2'b01;
   localparam logic [1:0] SUB_SETC = 2'b10;
   localparam logic [1:0] SUB_CLRC = 2'b11;

   localparam logic [1:0] SUB_NOT  = 2'b00;
   localparam logic [1:0] SUB_NEG  = 2'b01;
   localparam logic [1:0] SUB_INC  = 2'b10;
   localparam logic [1:0] SUB_DEC  = 2'b11;

   logic [7:0] res_q, res_d;
   logic       z_q, z_d;
   logic       n_q, n_d;
   logic       c_q, c_d;
   logic       v_q, v_d;

   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [1:0] ra;
   logic       upd_zn;

   assign ra    = bus.A[1:0];
   assign sum9  = {1'b0, bus.A} + {1'b0, bus.B};
   assign diff9 = {1'b0, bus.A} - {1'b0, bus.B};

   always_comb begin
      res_d  = res_q;
      z_d    = z_q;
      n_d    = n_q;
      c_d    = c_q;
      v_d    = v_q;
      upd_zn = 1'b0;

      case (bus.opcode)
`ifdef ALU_MOV_EN
         OP_MOV: begin
            res_d  = bus.B;
            upd_zn = 1'b1;
         end
`endif
         OP_ADD: begin
            res_d  = sum9[7:0];
            c_d    = sum9[8];
            v_d    = (bus.A[7] == bus.B[7]) && (sum9[7] != bus.A[7]);
            upd_zn = 1'b1;
         end
         OP_SUB: begin
            // bit 8 of the zero-extended difference is the unsigned borrow
            res_d  = diff9[7:0];
            c_d    = diff9[8];
            v_d    = (bus.A[7] != bus.B[7]) && (diff9[7] != bus.A[7]);
            upd_zn = 1'b1;
         end
         OP_AND: begin
            res_d  = bus.A & bus.B;
            upd_zn = 1'b1;
         end
         OP_OR: begin
            res_d  = bus.A | bus.B;
            upd_zn = 1'b1;
         end
         OP_ROT: begin
            case (ra)
               SUB_RLC: begin
                  res_d  = {bus.B[6:0], c_q};
                  c_d    = bus.B[7];
                  upd_zn = 1'b1;
               end
               SUB_RRC: begin
                  res_d  = {c_q, bus.B[7:1]};
                  c_d    = bus.B[0];
                  upd_zn = 1'b1;
               end
               SUB_SETC: c_d = 1'b1;
               SUB_CLRC: c_d = 1'b0;
               default:  c_d = c_q;
            endcase
         end
         OP_UNARY: begin
            upd_zn = 1'b1;
            case (ra)
               SUB_NOT: res_d = ~bus.B;
               SUB_NEG: begin
                  res_d = 8'h00 - bus.B;
                  v_d   = (bus.B == 8'h80);
               end
               SUB_INC: begin
                  res_d = bus.B + 8'h01;
                  v_d   = (bus.B == 8'h7F);
               end
               SUB_DEC: begin
                  res_d = bus.B - 8'h01;
                  v_d   = (bus.B == 8'h80);
               end
               default: res_d = res_q;
            endcase
         end
         OP_NOP:  res_d = res_q;
         default: res_d = res_q;
      endcase

      // Z/N always follow the freshly computed result, never the old one
      if (upd_zn) begin
         z_d = (res_d == 8'h00);
         n_d = res_d[7];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         res_q <= 8'h00;
         z_q   <= 1'b0;
         n_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
      end else begin
         res_q <= res_d;
         z_q   <= z_d;
         n_q   <= n_d;
         c_q   <= c_d;
         v_q   <= v_d;
      end
   end

   assign bus.ALU_OUT       = res_q;
   assign bus.Zero_Flag     = z_q;
   assign bus.Negative_Flag = n_q;
   assign bus.Carry_Flag    = c_q;
   assign bus.Overflow      = v_q;

endmodule

// File: tb/tb_alu.sv
// Directed + random bench for alu: a behavioural model pushes expected result/flags
// into a queue when an operation is driven; entries are popped and checked after the edge.
module tb_alu;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   alu_if bus ();

   alu dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] res;
      logic       z;
      logic       n;
      logic       c;
      logic       v;
   } exp_t;

   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   logic [7:0] m_res;
   logic       m_z, m_n, m_c, m_v;

   function automatic int to_signed8(input int u);
      return (u > 127) ? u - 256 : u;
   endfunction

   task automatic model_reset();
      m_res = 8'h00;
      m_z   = 1'b0;
      m_n   = 1'b0;
      m_c   = 1'b0;
      m_v   = 1'b0;
   endtask

   // Behavioural model written with integer arithmetic
   task automatic model_step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      int ai, bi, r, s, sel;
      bit upd;
      ai  = int'(a);
      bi  = int'(b);
      sel = ai % 4;
      r   = int'(m_res);
      upd = 1'b0;
      case (op)
`ifdef ALU_MOV_EN
         4'd1: begin r = bi; upd = 1'b1; end
`endif
         4'd2: begin
            s    = ai + bi;
            m_c  = (s > 255);
            r    = s % 256;
            s    = to_signed8(ai) + to_signed8(bi);
            m_v  = (s > 127) || (s < -128);
            upd  = 1'b1;
         end
         4'd3: begin
            m_c  = (ai < bi);
            r    = (ai - bi + 256) % 256;
            s    = to_signed8(ai) - to_signed8(bi);
            m_v  = (s > 127) || (s < -128);
            upd  = 1'b1;
         end
         4'd4: begin r = int'(a & b); upd = 1'b1; end
         4'd5: begin r = int'(a | b); upd = 1'b1; end
         4'd6: begin
            if (sel == 0) begin
               r   = (bi * 2) % 256 + (m_c ? 1 : 0);
               m_c = (bi >= 128);
               upd = 1'b1;
            end else if (sel == 1) begin
               r   = (m_c ? 128 : 0) + bi / 2;
               m_c = (bi % 2) == 1;
               upd = 1'b1;
            end else if (sel == 2) begin
               m_c = 1'b1;
            end else begin
               m_c = 1'b0;
            end
         end
         4'd8: begin
            upd = 1'b1;
            if (sel == 0) r = 255 - bi;
            else if (sel == 1) begin r = (256 - bi) % 256; m_v = (bi == 128); end
            else if (sel == 2) begin r = (bi + 1) % 256;   m_v = (bi == 127); end
            else begin r = (bi + 255) % 256; m_v = (bi == 128); end
         end
         default: ;
      endcase
      m_res = r[7:0];
      if (upd) begin
         m_z = (r == 0);
         m_n = (r >= 128);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      checks++;
      assert (bus.ALU_OUT === e.res) else begin
         errors++;
         $error("FAIL %s result: observed=%h expected=%h", tag, bus.ALU_OUT, e.res);
      end
      checks++;
      assert (bus.Zero_Flag === e.z) else begin
         errors++;
         $error("FAIL %s Z: observed=%b expected=%b", tag, bus.Zero_Flag, e.z);
      end
      checks++;
      assert (bus.Negative_Flag === e.n) else begin
         errors++;
         $error("FAIL %s N: observed=%b expected=%b", tag, bus.Negative_Flag, e.n);
      end
      checks++;
      assert (bus.Carry_Flag === e.c) else begin
         errors++;
         $error("FAIL %s C: observed=%b expected=%b", tag, bus.Carry_Flag, e.c);
      end
      checks++;
      assert (bus.Overflow === e.v) else begin
         errors++;
         $error("FAIL %s V: observed=%b expected=%b", tag, bus.Overflow, e.v);
      end
   endtask

   // Drive one op at the falling edge, commit at the rising edge, compare 1 ns later,
   // then disturb the inputs mid-cycle and confirm the registered outputs do not move.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op);
      exp_t e;
      @(negedge CLK);
      bus.A      = a;
      bus.B      = b;
      bus.opcode = op;
      model_step(a, b, op);
      exp_q.push_back('{res: m_res, z: m_z, n: m_n, c: m_c, v: m_v});
      @(posedge CLK);
      #1;
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL %s queue: observed=empty expected=entry", tag);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_outputs(tag, e);
         bus.A      = 8'($urandom);
         bus.B      = 8'($urandom);
         bus.opcode = 4'($urandom);
         #2;
         checks++;
         assert (bus.ALU_OUT === e.res && bus.Carry_Flag === e.c) else begin
            errors++;
            $error("FAIL %s hold: observed=%h/%b expected=%h/%b", tag,
                   bus.ALU_OUT, bus.Carry_Flag, e.res, e.c);
         end
      end
   endtask

   initial begin
      exp_t zero_e;
      zero_e = '{res: 8'h00, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0};
      bus.A      = 8'h00;
      bus.B      = 8'h00;
      bus.opcode = 4'h0;
      model_reset();

      #2;
      check_outputs("reset_async", zero_e);
      @(negedge CLK);
      RST = 1'b1;

      do_op("nop_after_reset", 8'h00, 8'h00, 4'b0000);
      do_op("add_carry",       8'hFF, 8'h02, 4'b0010);
      do_op("add_overflow",    8'h7F, 8'h01, 4'b0010);
      do_op("sub_15_10",       8'd15, 8'd10, 4'b0011);
      do_op("sub_borrow",      8'd5,  8'd10, 4'b0011);
      do_op("sub_zero",        8'd10, 8'd10, 4'b0011);
      do_op("sub_ovf",         8'h80, 8'h01, 4'b0011);
      do_op("and_zero",        8'hF0, 8'h0F, 4'b0100);
      do_op("or_ff",           8'hF0, 8'h0F, 4'b0101);
      do_op("rlc",             8'h00, 8'hAA, 4'b0110);
      do_op("rrc",             8'h01, 8'hAA, 4'b0110);
      do_op("setc",            8'h02, 8'hAA, 4'b0110);
      do_op("clrc",            8'h03, 8'hAA, 4'b0110);
      do_op("setc2",           8'h02, 8'h00, 4'b0110);
      do_op("rlc_b2b_1",       8'h00, 8'h80, 4'b0110);
      do_op("rlc_b2b_2",       8'h00, 8'h00, 4'b0110);
      do_op("rrc_b2b",         8'h01, 8'h01, 4'b0110);
      do_op("not",             8'h00, 8'hAA, 4'b1000);
      do_op("neg",             8'h01, 8'h05, 4'b1000);
      do_op("inc",             8'h02, 8'h2A, 4'b1000);
      do_op("dec",             8'h03, 8'h2A, 4'b1000);
      do_op("inc_7f",          8'h02, 8'h7F, 4'b1000);
      do_op("not_v_hold",      8'h00, 8'h00, 4'b1000);
      do_op("dec_80",          8'h03, 8'h80, 4'b1000);
      do_op("neg_80",          8'h01, 8'h80, 4'b1000);
      do_op("neg_00",          8'h01, 8'h00, 4'b1000);
      do_op("dec_00",          8'h03, 8'h00, 4'b1000);
      do_op("mov_or_nop",      8'h00, 8'h00, 4'b0001);
      do_op("mov_or_nop2",     8'h00, 8'h9C, 4'b0001);
      do_op("op7_nop",         8'h12, 8'h34, 4'b0111);
      do_op("op9_nop",         8'h12, 8'h34, 4'b1001);
      do_op("opf_nop",         8'h00, 8'h00, 4'b1111);

      for (int i = 0; i < 60; i++) begin
         do_op("random", 8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)));
      end

      do_op("pre_reset", 8'h01, 8'hFE, 4'b0010);
      @(negedge CLK);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      check_outputs("reset_midcycle", zero_e);
      @(posedge CLK);
      #1;
      check_outputs("reset_held", zero_e);
      @(negedge CLK);
      RST = 1'b1;
      do_op("first_after_release", 8'h80, 8'h80, 4'b0010);
      do_op("rlc_after_release",   8'h00, 8'h01, 4'b0110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu.md
# alu

Registered 8-bit arithmetic/logic unit of the pipelined processor's execute stage. Each rising CLK edge it computes one operation on operands A and B selected by a 4-bit opcode. It latches the 8-bit result and four condition flags (Z, N, C, V). The flags persist between operations; the carry flag also feeds the rotate-through-carry instructions.

## Interface
- No parameters; data width fixed at 8.
- CLK — input, 1 — single system clock, all state updates on rising edge.
- RST — input, 1 — reset, asynchronous, active-low; clears all registers.
- A — input, 8 — operand A; for opcodes 0110/1000, A[1:0] is the sub-operation select (ra field).
- B — input, 8 — operand B; sole operand for unary/rotate ops.
- opcode — input, 4 — operation select.
- ALU_OUT — output, 8 — registered result.
- Zero_Flag — output, 1 — registered Z.
- Negative_Flag — output, 1 — registered N.
- Carry_Flag — output, 1 — registered C (carry / borrow / rotated-out bit).
- Overflow — output, 1 — registered V (signed overflow).

## Operation
- 0000 NOP: result and all flags hold.
- 0001 MOV (see Configuration): result = B; Z, N updated; C, V hold.
- 0010 ADD: {C,result} = A + B (9-bit); V = (A[7]==B[7]) && (result[7]!=A[7]); Z, N updated.
- 0011 SUB: result = A − B mod 256; C = borrow (1 iff A < B unsigned); V = (A[7]!=B[7]) && (result[7]!=A[7]); Z, N updated.
- 0100 AND: result = A & B; Z, N updated; C, V hold.
- 0101 OR: result = A | B; Z, N updated; C, V hold.
- 0110, by A[1:0]:
  - 00 RLC: result = {B[6:0], C_old}, C = B[7].
  - 01 RRC: result = {C_old, B[7:1]}, C = B[0].
  - For RLC/RRC, Z and N are updated and V holds.
  - 10 SETC: C = 1; result, Z, N, V hold.
  - 11 CLRC: C = 0; result, Z, N, V hold.
- 1000, by A[1:0]:
  - 00 NOT: result = ~B.
  - 01 NEG: result = 0 − B; V = (B == 8'h80).
  - 10 INC: result = B + 1; V = (B == 8'h7F).
  - 11 DEC: result = B − 1; V = (B == 8'h80).
  - For all four, Z and N are updated. C holds. NOT leaves V holding; NEG, INC and DEC update V as given.
- All other opcodes (0111, 1001–1111): treated as NOP.
- Z = (result == 0); N = result[7]; both are computed on the new result, only when updated.
- All arithmetic wraps modulo 256.

## Timing
- RST low, at any time and independent of CLK: ALU_OUT = 8'h00 and Z = N = C = V = 0 immediately. These values hold while RST stays low.
- Latency 1 cycle: inputs sampled at rising edge k; result and flags are valid after edge k and stable until edge k+1.
- No handshake: a new operation may be issued every cycle. Back-to-back rotates use the C written by the previous edge.
- Reset released mid-stream: the first edge with RST high executes the opcode presented at that edge.
- Inputs are only sampled at edges; changes between edges have no effect.

## Configuration
- Macro ALU_MOV_EN.
- Defined: opcode 0001 is MOV as specified.
- Undefined: opcode 0001 behaves as NOP (result and flags hold).
- All other behaviour is identical in both builds.

## Test plan
- Reset, then A=00, B=00, op=0000; after one edge → ALU_OUT=00, Z=0, all flags 0.
- ADD: A=FF, B=02 → ALU_OUT=01, C=1. Then A=7F, B=01 → ALU_OUT=80, V=1, N=1.
- SUB: 15−10 → 05, C=0. Then 5−10 → FB, C=1, N=1. Then 10−10 → 00, Z=1.
- Logic: AND F0&0F → 00, Z=1. OR F0|0F → FF, N=1.
- 0110 with B=AA:
  - RLC (A=0) → C=1.
  - RRC (A=1) → C=0.
  - SETC (A=2) → C=1.
  - CLRC (A=3) → C=0, ALU_OUT unchanged.
- 1000:
  - NOT AA → 55.
  - NEG 05 → FB, N=1.
  - INC 2A → 2B.
  - DEC 2A → 29.
  - Finally, assert RST mid-cycle → all outputs 0 before the next edge.
